// File: rtl/decode_stage_p.sv
// decode_stage_p: instruction decode stage with register file, write-to-read
// bypass, load-use hazard detection and the ID/EX pipeline register.
// Ports:
//   clk, rst (async, active-low)
//   decode side : instr_d, valid_d, pc_d, pc_plus4_d, ctrl_d, mem_read_d, imm_d
//   writeback    : wb_we, wb_rd, wb_data
//   control      : stall_ext, flush in; stall_d out (combinational)
//   ID/EX        : valid_e, ctrl_e, mem_read_e, rs1_data_e, rs2_data_e,
//                  imm_e, pc_e, pc_plus4_e, rd_e, rs1_e, rs2_e
module decode_stage_p #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned CTRL_W    = 12,
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_d,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              mem_read_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              stall_ext,
  input  logic              flush,
  output logic              stall_d,
  output logic              valid_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic              mem_read_e,
  output logic [XLEN-1:0]   rs1_data_e,
  output logic [XLEN-1:0]   rs2_data_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [4:0]        rd_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e
);

  localparam int unsigned AW = $clog2(NREG);

  logic [4:0]      rs1Field, rs2Field, rdField;
  logic [AW-1:0]   rs1Idx, rs2Idx, wbIdx;
  logic [XLEN-1:0] rs1Data, rs2Data;
  logic            loadUse;
  logic [XLEN-1:0] regFile [NREG];

  // Opcode/funct bits and any high index bits are not used by this stage.
  logic unusedBits;
  assign unusedBits = ^{instr_d[31:25], instr_d[14:12], instr_d[6:0], wb_rd};

  assign rs1Field = instr_d[19:15];
  assign rs2Field = instr_d[24:20];
  assign rdField  = instr_d[11:7];
  assign rs1Idx   = rs1Field[AW-1:0];
  assign rs2Idx   = rs2Field[AW-1:0];
  assign wbIdx    = wb_rd[AW-1:0];

  // Register file; entry 0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) regFile[i] <= '0;
    end else if (wb_we && (wbIdx != '0)) begin
      regFile[wbIdx] <= wb_data;
    end
  end

  // Combinational operand read with optional same-cycle writeback bypass.
  always_comb begin
    rs1Data = '0;
    rs2Data = '0;
    if (rs1Idx != '0) begin
      rs1Data = regFile[rs1Idx];
      if ((WB_BYPASS != 0) && wb_we && (wbIdx == rs1Idx)) rs1Data = wb_data;
    end
    if (rs2Idx != '0) begin
      rs2Data = regFile[rs2Idx];
      if ((WB_BYPASS != 0) && wb_we && (wbIdx == rs2Idx)) rs2Data = wb_data;
    end
  end

  // Load in EX whose destination feeds the instruction in decode.
  assign loadUse = valid_e && mem_read_e && (rd_e != 5'd0) && valid_d &&
                   ((rd_e == rs1Field) || (rd_e == rs2Field));

  assign stall_d = (loadUse || stall_ext) && !flush;

  // ID/EX register: flush > stall_ext hold > load-use bubble > load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e    <= 1'b0;
      ctrl_e     <= '0;
      mem_read_e <= 1'b0;
      rs1_data_e <= '0;
      rs2_data_e <= '0;
      imm_e      <= '0;
      pc_e       <= '0;
      pc_plus4_e <= '0;
      rd_e       <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
    end else if (flush || (!stall_ext && loadUse)) begin
      valid_e    <= 1'b0;
      ctrl_e     <= '0;
      mem_read_e <= 1'b0;
      rs1_data_e <= '0;
      rs2_data_e <= '0;
      imm_e      <= '0;
      pc_e       <= '0;
      pc_plus4_e <= '0;
      rd_e       <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
    end else if (!stall_ext) begin
      // An invalid slot still carries its data but no side effects.
      valid_e    <= valid_d;
      ctrl_e     <= valid_d ? ctrl_d : '0;
      mem_read_e <= valid_d && mem_read_d;
      rd_e       <= valid_d ? rdField : 5'd0;
      rs1_data_e <= rs1Data;
      rs2_data_e <= rs2Data;
      imm_e      <= imm_d;
      pc_e       <= pc_d;
      pc_plus4_e <= pc_plus4_d;
      rs1_e      <= rs1Field;
      rs2_e      <= rs2Field;
    end
  end

endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32, datapath width.
- NREG, default 32, register count (32 or 16); AW = log2(NREG).
- CTRL_W, default 12, width of opaque control bundle.
- WB_BYPASS, default 1, enables write-to-read bypass.

REQ-002 Ports SHALL be:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- instr_d  input  32  instruction in decode.
- valid_d  input  1  instr_d is valid.
- pc_d  input  XLEN  instruction PC.
- pc_plus4_d  input  XLEN  PC+4.
- ctrl_d  input  CTRL_W  decoded control bundle.
- mem_read_d  input  1  instruction is a load.
- imm_d  input  XLEN  extended immediate.
- wb_we  input  1  writeback enable.
- wb_rd  input  5  writeback register.
- wb_data  input  XLEN  writeback value.
- stall_ext  input  1  downstream hold request.
- flush  input  1  squash decode and ID/EX.
- stall_d  output  1  hold fetch and IF/ID.
- valid_e  output  1  ID/EX holds a live instruction.
- ctrl_e  output  CTRL_W  registered control.
- mem_read_e  output  1  registered load flag.
- rs1_data_e, rs2_data_e  output  XLEN  registered operands.
- imm_e, pc_e, pc_plus4_e  output  XLEN  registered copies.
- rd_e, rs1_e, rs2_e  output  5  registered register indices.

Function
REQ-003 Register file SHALL hold NREG x XLEN entries; register index = low AW bits of the 5-bit field.
REQ-004 Write SHALL occur on posedge clk when wb_we=1 and the indexed register is not 0; register 0 SHALL always read 0.
REQ-005 Reads SHALL be combinational on rs1=instr_d[19:15] and rs2=instr_d[24:20].
REQ-006 When WB_BYPASS=1, wb_we=1, wb_rd equals the source index and the source index is not 0, read data SHALL be wb_data in the same cycle. When WB_BYPASS=0, the old register value SHALL be returned.
REQ-007 load_use SHALL be asserted when all of the following hold: valid_e, mem_read_e, rd_e!=0, valid_d, and (rd_e==rs1 or rd_e==rs2).
REQ-008 stall_d SHALL equal (load_use or stall_ext) and not flush; it is purely combinational.
REQ-009 ID/EX update priority on posedge clk SHALL be:
- flush: bubble.
- else stall_ext: hold all fields.
- else load_use: bubble.
- else load all fields from decode.
REQ-010 Bubble SHALL set valid_e=0, ctrl_e=0, mem_read_e=0 and rd_e=rs1_e=rs2_e=0, and SHALL zero all data fields.
REQ-011 Load with valid_d=0 SHALL produce valid_e=0, ctrl_e=0, mem_read_e=0 and rd_e=0; data fields are loaded as presented.
REQ-012 Latency from decode to ID/EX outputs SHALL be one cycle.
REQ-013 A same-cycle regfile write and ID/EX capture SHALL capture the bypassed value when WB_BYPASS=1.
REQ-014 Simultaneous flush and stall_ext SHALL produce a bubble, not a hold.
REQ-015 A load-use bubble SHALL last exactly one cycle unless stall_ext also holds.

Reset
REQ-016 rst=0 SHALL immediately clear all ID/EX outputs and all register file entries to 0, independent of clk.
REQ-017 Reset asserted mid-stall SHALL leave stall_d=0 once valid_e=0.
REQ-018 The first load after rst rises SHALL occur on the first posedge with rst=1.

Verification
REQ-019 Write 0x0000_00AA to x5, then decode rs1=x5 with valid_d=1 -> next cycle rs1_data_e=0x0000_00AA, valid_e=1.
REQ-020 Write wb_rd=0, wb_data=0xFFFF_FFFF, then read x0 -> rs1_data_e=0.
REQ-021 Same cycle wb_we=1, wb_rd=7, wb_data=0x1234 with decode reading rs2=x7 -> rs2_data_e=0x1234 (WB_BYPASS=1); old value when WB_BYPASS=0.
REQ-022 Load to rd=3 in EX, decode reads rs1=x3 -> stall_d=1 for one cycle, then valid_e=0 bubble, then instruction issues with valid_e=1.
REQ-023 flush=1 and stall_ext=1 in the same cycle with valid ID/EX -> valid_e=0, ctrl_e=0 next cycle.
REQ-024 NREG=16: write wb_rd=21 (index 5) -> x5 updated; rst=0 mid-cycle -> all outputs 0 before the next edge.
